// File: rtl/tl_error_sink_if.sv
// TileLink link bundle (A/B/C/D/E channels) between a socket and an attached device.
// host/master drives A, C and E; device/slave drives B and D.
interface tl_channel #(
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64,
  parameter int SizeWidth   = 3
);
  localparam int MaskWidth = DataWidth / 8;

  logic                   a_valid, a_ready, a_corrupt;
  logic [2:0]             a_opcode, a_param;
  logic [SizeWidth-1:0]   a_size;
  logic [SourceWidth-1:0] a_source;
  logic [AddrWidth-1:0]   a_address;
  logic [MaskWidth-1:0]   a_mask;
  logic [DataWidth-1:0]   a_data;

  logic                   b_valid, b_ready, b_corrupt;
  logic [2:0]             b_opcode;
  logic [1:0]             b_param;
  logic [SizeWidth-1:0]   b_size;
  logic [SourceWidth-1:0] b_source;
  logic [AddrWidth-1:0]   b_address;
  logic [MaskWidth-1:0]   b_mask;
  logic [DataWidth-1:0]   b_data;

  logic                   c_valid, c_ready, c_corrupt;
  logic [2:0]             c_opcode, c_param;
  logic [SizeWidth-1:0]   c_size;
  logic [SourceWidth-1:0] c_source;
  logic [AddrWidth-1:0]   c_address;
  logic [DataWidth-1:0]   c_data;

  logic                   d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]             d_opcode;
  logic [1:0]             d_param;
  logic [SizeWidth-1:0]   d_size;
  logic [SourceWidth-1:0] d_source;
  logic [SinkWidth-1:0]   d_sink;
  logic [DataWidth-1:0]   d_data;

  logic                   e_valid, e_ready;
  logic [SinkWidth-1:0]   e_sink;

  modport host (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
    output b_ready,
    output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
    input  c_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready
  );

  modport device (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
    input  b_ready,
    input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
    output c_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
    output b_ready,
    output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
    input  c_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
    input  b_ready,
    input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
    output c_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready
  );
endinterface

// File: rtl/tl_error_sink.sv
// Terminating TileLink device: swallows every A/C message (whole bursts) and answers it
// with a denied D response of the proper size. ProbeAcks get no response; no probes are issued.
module tl_error_sink #(
  parameter int          SourceWidth = 1,
  parameter int          SinkWidth   = 1,
  parameter int          AddrWidth   = 56,
  parameter int          DataWidth   = 64,
  parameter int          SizeWidth   = 3,
  parameter int          MaxSize     = 6,
  parameter int unsigned SinkId      = 0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  tl_channel.device host
);
  localparam int NonBurstSize = $clog2(DataWidth / 8);
  localparam int CntWidth     = (MaxSize > NonBurstSize) ? MaxSize - NonBurstSize : 1;

  if ($bits(host.a_source) != SourceWidth || $bits(host.d_sink) != SinkWidth ||
      $bits(host.a_address) != AddrWidth || $bits(host.a_data) != DataWidth ||
      $bits(host.a_size) != SizeWidth) begin : g_param_mismatch
    $fatal(1, "tl_error_sink: host link parameters do not match the block parameters");
  end

  typedef enum logic [1:0] {IDLE, A_DRAIN, C_DRAIN, RESP} state_e;

  function automatic logic [CntWidth-1:0] beats_m1(input logic [SizeWidth-1:0] size);
    int shift;
    shift = int'(size) - NonBurstSize;
    if (shift <= 0) return '0;
    return CntWidth'((32'd1 << shift) - 32'd1);
  endfunction

  function automatic logic [CntWidth-1:0] a_resp_m1(input logic [2:0] op,
                                                    input logic [SizeWidth-1:0] size);
    return (op inside {3'd2, 3'd3, 3'd4}) ? beats_m1(size) : '0;
  endfunction

  state_e                 state_reg, state_next;
  logic [CntWidth-1:0]    cnt_reg, cnt_next;
  logic                   is_c_reg, is_c_next;
  logic [2:0]             opcode_reg, opcode_next;
  logic [SizeWidth-1:0]   size_reg, size_next;
  logic [SourceWidth-1:0] source_reg, source_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      is_c_reg   <= 1'b0;
      opcode_reg <= '0;
      size_reg   <= '0;
      source_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      is_c_reg   <= is_c_next;
      opcode_reg <= opcode_next;
      size_reg   <= size_next;
      source_reg <= source_next;
    end
  end

  // One counter serves both phases: remaining request beats, then remaining response beats.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    is_c_next    = is_c_reg;
    opcode_next  = opcode_reg;
    size_next    = size_reg;
    source_next  = source_reg;
    host.a_ready = 1'b0;
    host.c_ready = 1'b0;
    unique case (state_reg)
      IDLE: begin
        host.c_ready = 1'b1;
        host.a_ready = !host.c_valid;
        if (host.c_valid) begin
          is_c_next   = 1'b1;
          opcode_next = host.c_opcode;
          size_next   = host.c_size;
          source_next = host.c_source;
          cnt_next    = (host.c_opcode[2] && host.c_opcode[0]) ? beats_m1(host.c_size) : '0;
          if (cnt_next != '0)                  state_next = C_DRAIN;
          else if (host.c_opcode[2:1] != 2'b10) state_next = RESP;
        end else if (host.a_valid) begin
          is_c_next   = 1'b0;
          opcode_next = host.a_opcode;
          size_next   = host.a_size;
          source_next = host.a_source;
          cnt_next    = !host.a_opcode[2] ? beats_m1(host.a_size) : '0;
          if (cnt_next != '0) begin
            state_next = A_DRAIN;
          end else begin
            state_next = RESP;
            cnt_next   = a_resp_m1(host.a_opcode, host.a_size);
          end
        end
      end
      A_DRAIN: begin
        host.a_ready = 1'b1;
        if (host.a_valid) begin
          if (cnt_reg == CntWidth'(1)) begin
            state_next = RESP;
            cnt_next   = a_resp_m1(opcode_reg, size_reg);
          end else begin
            cnt_next = cnt_reg - CntWidth'(1);
          end
        end
      end
      C_DRAIN: begin
        host.c_ready = 1'b1;
        if (host.c_valid) begin
          if (cnt_reg == CntWidth'(1)) begin
            state_next = (opcode_reg[2:1] == 2'b10) ? IDLE : RESP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CntWidth'(1);
          end
        end
      end
      RESP: begin
        if (host.d_ready) begin
          if (cnt_reg == '0) state_next = IDLE;
          else               cnt_next   = cnt_reg - CntWidth'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // D payload is a pure function of registered state, so it holds steady through stalls.
  always_comb begin
    host.d_valid   = 1'b0;
    host.d_opcode  = 3'd0;
    host.d_param   = 2'd0;
    host.d_size    = '0;
    host.d_source  = '0;
    host.d_sink    = '0;
    host.d_denied  = 1'b0;
    host.d_data    = '0;
    host.d_corrupt = 1'b0;
    if (state_reg == RESP) begin
      host.d_valid  = 1'b1;
      host.d_denied = 1'b1;
      host.d_size   = size_reg;
      host.d_source = source_reg;
      if (is_c_reg) begin
        host.d_opcode = 3'd6;
      end else begin
        case (opcode_reg)
          3'd0, 3'd1:       host.d_opcode = 3'd0;
          3'd2, 3'd3, 3'd4: begin
            host.d_opcode  = 3'd1;
            host.d_corrupt = 1'b1;
          end
          3'd5:             host.d_opcode = 3'd2;
          default: begin
            host.d_opcode = 3'd4;
            host.d_param  = 2'd2;
            host.d_sink   = SinkWidth'(SinkId);
          end
        endcase
      end
    end
  end

  assign host.b_valid   = 1'b0;
  assign host.b_opcode  = '0;
  assign host.b_param   = '0;
  assign host.b_size    = '0;
  assign host.b_source  = '0;
  assign host.b_address = '0;
  assign host.b_mask    = '0;
  assign host.b_data    = '0;
  assign host.b_corrupt = 1'b0;
  assign host.e_ready   = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{host.a_param, host.a_address, host.a_mask, host.a_data,
                           host.a_corrupt, host.b_ready, host.c_param, host.c_address,
                           host.c_data, host.c_corrupt, host.e_valid, host.e_sink};

  a_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_reg == IDLE && host.a_valid && host.a_ready) |-> (int'(host.a_size) <= MaxSize));
  c_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_reg == IDLE && host.c_valid) |-> (int'(host.c_size) <= MaxSize));
endmodule

// File: tb/tb_tl_error_sink.sv
// Directed bench for tl_error_sink: expected D beats are queued when requests are driven
// and checked by a negedge monitor as the DUT emits them.
module tb_tl_error_sink;
  localparam int SourceWidth = 1;
  localparam int SinkWidth   = 1;
  localparam int AddrWidth   = 56;
  localparam int DataWidth   = 64;
  localparam int SizeWidth   = 3;
  localparam int MaxSize     = 6;
  localparam int SinkId      = 1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic        source;
    logic        sink;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } d_beat_t;

  typedef struct {
    bit         is_c;
    logic [2:0] op;
    logic [2:0] size;
    logic       src;
  } msg_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  tl_channel #(.SourceWidth(SourceWidth), .SinkWidth(SinkWidth), .AddrWidth(AddrWidth),
               .DataWidth(DataWidth), .SizeWidth(SizeWidth)) host ();

  tl_error_sink #(.SourceWidth(SourceWidth), .SinkWidth(SinkWidth), .AddrWidth(AddrWidth),
                  .DataWidth(DataWidth), .SizeWidth(SizeWidth), .MaxSize(MaxSize),
                  .SinkId(SinkId)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .host (host)
  );

  int      n_tests = 0;
  int      n_fail  = 0;
  d_beat_t exp_q[$];
  d_beat_t held;
  bit      held_vld = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic d_beat_t obs();
    return '{host.d_opcode, host.d_param, host.d_size, host.d_source, host.d_sink,
             host.d_denied, host.d_corrupt, host.d_data};
  endfunction

  function automatic d_beat_t mk(input logic [2:0] op, input logic [1:0] param,
                                 input logic [2:0] size, input logic src,
                                 input logic sink, input logic corrupt);
    return '{op, param, size, src, sink, 1'b1, corrupt, 64'd0};
  endfunction

  function automatic int req_beats(input bit is_c, input logic [2:0] op, input logic [2:0] size);
    bit data;
    data = is_c ? (op == 3'd5 || op == 3'd7) : (op <= 3'd3);
    return (data && size > 3'd3) ? (1 << (int'(size) - 3)) : 1;
  endfunction

  task automatic push_resp(input bit is_c, input logic [2:0] op, input logic [2:0] size,
                           input logic src);
    int n;
    n = (size <= 3'd3) ? 1 : (1 << (int'(size) - 3));
    if (is_c) begin
      if (op == 3'd6 || op == 3'd7) exp_q.push_back(mk(3'd6, 2'd0, size, src, 1'b0, 1'b0));
    end else begin
      case (op)
        3'd0, 3'd1:       exp_q.push_back(mk(3'd0, 2'd0, size, src, 1'b0, 1'b0));
        3'd2, 3'd3, 3'd4: for (int i = 0; i < n; i++) exp_q.push_back(mk(3'd1, 2'd0, size, src, 1'b0, 1'b1));
        3'd5:             exp_q.push_back(mk(3'd2, 2'd0, size, src, 1'b0, 1'b0));
        default:          exp_q.push_back(mk(3'd4, 2'd2, size, src, 1'(SinkId), 1'b0));
      endcase
    end
  endtask

  // Monitor: pops the scoreboard on each D handshake and checks payload hold across stalls.
  always @(negedge clk_i) begin
    if (rst_i) begin
      held_vld = 0;
    end else begin
      if (held_vld) check("d_hold", {host.d_valid, obs()}, {1'b1, held});
      held_vld = 0;
      if (host.d_valid && host.d_ready) begin
        if (exp_q.size() == 0) check("d_unexpected", host.d_valid, 1'b0);
        else check("d_beat", obs(), exp_q.pop_front());
      end else if (host.d_valid) begin
        held     = obs();
        held_vld = 1;
      end
    end
  end

  task automatic a_beat(input logic [2:0] op, input logic [2:0] size, input logic src,
                        input bit expect_ready);
    int t;
    host.a_valid  = 1'b1;
    host.a_opcode = op;
    host.a_size   = size;
    host.a_source = src;
    host.a_data   = {$urandom, $urandom};
    @(negedge clk_i);
    if (expect_ready) check("a_ready_drain", host.a_ready, 1'b1);
    t = 0;
    while (!host.a_ready && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (!host.a_ready) check("a_accept_timeout", host.a_ready, 1'b1);
    @(posedge clk_i); #1;
    host.a_valid = 1'b0;
  endtask

  task automatic c_beat(input logic [2:0] op, input logic [2:0] size, input logic src,
                        input bit expect_ready);
    int t;
    host.c_valid  = 1'b1;
    host.c_opcode = op;
    host.c_size   = size;
    host.c_source = src;
    host.c_data   = {$urandom, $urandom};
    @(negedge clk_i);
    if (expect_ready) check("c_ready_drain", host.c_ready, 1'b1);
    t = 0;
    while (!host.c_ready && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (!host.c_ready) check("c_accept_timeout", host.c_ready, 1'b1);
    @(posedge clk_i); #1;
    host.c_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit toggle);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || host.d_valid) && t < 200) begin
      @(posedge clk_i); #1;
      if (toggle) host.d_ready = ~host.d_ready;
      @(negedge clk_i);
      t++;
    end
    check("resp_complete", {host.d_valid, 32'(exp_q.size())}, 33'd0);
    @(posedge clk_i); #1;
    host.d_ready = 1'b1;
  endtask

  task automatic send_msg(input msg_t m);
    int n;
    n = req_beats(m.is_c, m.op, m.size);
    push_resp(m.is_c, m.op, m.size, m.src);
    for (int i = 0; i < n; i++) begin
      if (m.is_c) c_beat(m.op, m.size, m.src, i > 0);
      else        a_beat(m.op, m.size, m.src, i > 0);
    end
    wait_resp(1'b0);
    @(negedge clk_i);
    check("back_to_idle", {host.a_ready, host.c_ready}, 2'b11);
    @(posedge clk_i); #1;
  endtask

  msg_t tbl[8] = '{
    '{1'b0, 3'd1, 3'd2, 1'b1},   // PutPartial, single beat
    '{1'b0, 3'd2, 3'd6, 1'b0},   // Arith burst: 8 in, 8 data out
    '{1'b0, 3'd3, 3'd4, 1'b1},   // Logical: 2 in, 2 out
    '{1'b0, 3'd5, 3'd6, 1'b0},   // Hint
    '{1'b0, 3'd7, 3'd6, 1'b1},   // AcquirePerm
    '{1'b1, 3'd5, 3'd6, 1'b1},   // ProbeAckData: no response
    '{1'b1, 3'd4, 3'd3, 1'b0},   // ProbeAck: no response
    '{1'b1, 3'd6, 3'd6, 1'b1}    // Release
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    host.a_valid = 0; host.a_opcode = 0; host.a_param = 0; host.a_size = 0; host.a_source = 0;
    host.a_address = 0; host.a_mask = '1; host.a_data = 0; host.a_corrupt = 0;
    host.b_ready = 1;
    host.c_valid = 0; host.c_opcode = 0; host.c_param = 0; host.c_size = 0; host.c_source = 0;
    host.c_address = 0; host.c_data = 0; host.c_corrupt = 0;
    host.d_ready = 1; host.e_valid = 0; host.e_sink = 0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_d_valid", host.d_valid, 1'b0);
    check("rst_b_valid", host.b_valid, 1'b0);
    check("rst_e_ready", host.e_ready, 1'b1);
    check("rst_d_payload", obs(), '0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    check("idle_ready", {host.a_ready, host.c_ready}, 2'b11);
    @(posedge clk_i); #1;

    // Get size 3: single data beat the cycle after the handshake
    push_resp(1'b0, 3'd4, 3'd3, 1'b1);
    a_beat(3'd4, 3'd3, 1'b1, 1'b0);
    @(negedge clk_i);
    check("get_latency", host.d_valid, 1'b1);
    check("resp_blocks_a", {host.a_ready, host.c_ready}, 2'b00);
    wait_resp(1'b0);

    // PutFull size 6 with a one-cycle gap between beats
    push_resp(1'b0, 3'd0, 3'd6, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk_i);
        check("put_gap_no_d", host.d_valid, 1'b0);
        @(posedge clk_i); #1;
      end
      a_beat(3'd0, 3'd6, 1'b1, i > 0);
    end
    @(negedge clk_i);
    check("put_latency", host.d_valid, 1'b1);
    wait_resp(1'b0);

    // Get size 6 with d_ready toggling every cycle
    push_resp(1'b0, 3'd4, 3'd6, 1'b0);
    a_beat(3'd4, 3'd6, 1'b0, 1'b0);
    wait_resp(1'b1);

    // AcquireBlock then GrantAck on E
    push_resp(1'b0, 3'd6, 3'd6, 1'b0);
    a_beat(3'd6, 3'd6, 1'b0, 1'b0);
    wait_resp(1'b0);
    host.e_valid = 1'b1;
    host.e_sink  = 1'(SinkId);
    @(negedge clk_i);
    check("e_ready", host.e_ready, 1'b1);
    @(posedge clk_i); #1;
    host.e_valid = 1'b0;

    // A and C together: ReleaseData wins, Get waits
    push_resp(1'b1, 3'd7, 3'd6, 1'b0);
    push_resp(1'b0, 3'd4, 3'd3, 1'b1);
    host.a_valid = 1'b1; host.a_opcode = 3'd4; host.a_size = 3'd3; host.a_source = 1'b1;
    host.c_valid = 1'b1; host.c_opcode = 3'd7; host.c_size = 3'd6; host.c_source = 1'b0;
    @(negedge clk_i);
    check("prio_ready", {host.a_ready, host.c_ready}, 2'b01);
    @(posedge clk_i); #1;
    for (int i = 1; i < 8; i++) begin
      c_beat(3'd7, 3'd6, 1'b0, 1'b1);
      check("a_stalled", host.a_ready, 1'b0);
    end
    @(negedge clk_i);
    check("release_ack_valid", {host.d_valid, host.d_opcode}, {1'b1, 3'd6});
    @(posedge clk_i); #1;
    a_beat(3'd4, 3'd3, 1'b1, 1'b0);
    wait_resp(1'b0);

    // Reset during the 4th beat of a PutFull burst
    for (int i = 0; i < 3; i++) a_beat(3'd0, 3'd6, 1'b0, i > 0);
    host.a_valid = 1'b1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    host.a_valid = 1'b0;
    @(negedge clk_i);
    check("mid_rst_d_valid", host.d_valid, 1'b0);
    check("mid_rst_payload", obs(), '0);
    check("mid_rst_ready", {host.a_ready, host.c_ready, host.e_ready, host.b_valid}, 4'b1110);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    send_msg('{1'b0, 3'd4, 3'd3, 1'b0});

    foreach (tbl[i]) send_msg(tbl[i]);

    repeat (5) @(posedge clk_i);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
